// File: rtl/fsm_stream_arbiter.sv
// fsm_stream_arbiter
// Round-robin time-sharing controller for one 4-state Mealy bit-transducer.
// Up to N_REQ requesters submit WORD_W-bit words. The granted word is
// serialised LSB-first through the transducer, and the output bits are
// returned as a parallel result.
//
// Optional feature, macro FSM_CTX_SAVE_EN:
//   defined     -> per-requester 2-bit transducer context is saved at the end
//                  of each job and restored at the start of that requester's
//                  next job.
//   not defined -> every job starts the transducer from S0.
//
// Handshake (req/grant): req is a level request. In IDLE the controller
// samples req and data_in on one edge. It then raises grant for the chosen
// requester for WORD_W+1 cycles, and the word is captured on that same edge.
// While a job runs, req and data_in are ignored. done pulses for one cycle,
// with result and done_id valid, during the last granted cycle.
module fsm_stream_arbiter #(
  parameter int N_REQ  = 2,
  parameter int WORD_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WORD_W-1:0] data_in,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              done_id,
  output logic [WORD_W-1:0]       result,
  output logic [1:0]              tx_state
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } ctrl_t;

  ctrl_t             ctrl;
  logic [1:0]        rr_ptr;
  logic [1:0]        owner;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] shadow;
  logic [CNT_W-1:0]  cnt;

`ifdef FSM_CTX_SAVE_EN
  logic [1:0] ctx [N_REQ];
`endif

  logic              pick_found;
  logic [1:0]        pick_idx;
  logic [1:0]        next_ptr;
  logic [WORD_W-1:0] sel_word;
  logic [1:0]        start_state;
  logic              bit_in;
  logic              tx_out;
  logic [1:0]        tx_nxt;
  logic [WORD_W-1:0] shadow_next;
  logic              last_bit;

  // Round-robin pick: first asserted req at or above rr_ptr, wrapping
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'b00;
    for (int k = 0; k < N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!pick_found && req[j] && (j == ((int'(rr_ptr) + k) % N_REQ))) begin
          pick_found = 1'b1;
          pick_idx   = 2'(j);
        end
      end
    end
    next_ptr = (pick_idx == 2'(N_REQ - 1)) ? 2'b00 : pick_idx + 2'b01;
  end

  // Select the winner's word and its starting transducer state
  always_comb begin
    sel_word    = '0;
    start_state = 2'b00;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == 2'(i)) begin
        sel_word = data_in[i*WORD_W +: WORD_W];
`ifdef FSM_CTX_SAVE_EN
        start_state = ctx[i];
`endif
      end
    end
  end

  // Mealy transducer: next state and output for the current bit
  always_comb begin
    bit_in = word[cnt];
    tx_out = bit_in;
    tx_nxt = 2'b00;
    case (tx_state)
      2'b00: tx_nxt = bit_in ? 2'b01 : 2'b00;
      2'b01: begin
        tx_nxt = bit_in ? 2'b11 : 2'b10;
        tx_out = ~bit_in;
      end
      2'b10: tx_nxt = bit_in ? 2'b11 : 2'b00;
      2'b11: tx_nxt = bit_in ? 2'b00 : 2'b11;
      default: tx_nxt = 2'b00;
    endcase
    shadow_next      = shadow;
    shadow_next[cnt] = tx_out;
    last_bit         = (cnt == CNT_W'(WORD_W - 1));
  end

  // Controller FSM with registered outputs; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      done_id  <= 2'b00;
      result   <= '0;
      tx_state <= 2'b00;
      rr_ptr   <= 2'b00;
      owner    <= 2'b00;
      word     <= '0;
      shadow   <= '0;
      cnt      <= '0;
`ifdef FSM_CTX_SAVE_EN
      for (int i = 0; i < N_REQ; i++) ctx[i] <= 2'b00;
`endif
    end else begin
      done <= 1'b0;
      case (ctrl)
        IDLE: begin
          if (pick_found) begin
            word     <= sel_word;
            tx_state <= start_state;
            grant    <= N_REQ'(1) << pick_idx;
            busy     <= 1'b1;
            cnt      <= '0;
            owner    <= pick_idx;
            rr_ptr   <= next_ptr;
            ctrl     <= SHIFT;
          end
        end
        SHIFT: begin
          shadow   <= shadow_next;
          tx_state <= tx_nxt;
          cnt      <= cnt + 1'b1;
          if (last_bit) begin
            ctrl    <= DONE;
            done    <= 1'b1;
            result  <= shadow_next;
            done_id <= owner;
`ifdef FSM_CTX_SAVE_EN
            for (int i = 0; i < N_REQ; i++) begin
              if (owner == 2'(i)) ctx[i] <= tx_nxt;
            end
`endif
          end
        end
        DONE: begin
          ctrl  <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
        default: ctrl <= IDLE;
      endcase
    end
  end

endmodule
